// File: rtl/spectrum_pkg.sv
// +--------------------------------------------------------------------+
// | spectrum_pkg: shared widths, FSM encoding and filter step helper    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package spectrum_pkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 9;

  typedef enum logic [0:0] {
    ST_SWEEP = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Shifted difference, never smaller than one so the filter always moves toward the target.
  function automatic logic [31:0] min_step(input logic [31:0] diff, input int unsigned shift);
    logic [31:0] s;
    s = diff >> shift;
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spectrum_smoother_bin_ram.sv
// +--------------------------------------------------------------------+
// | bin_ram: simple dual-port RAM, registered read, old data on RDW     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module bin_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8,
  parameter int unsigned W     = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

`default_nettype wire

// File: rtl/spectrum_smoother.sv
// +--------------------------------------------------------------------+
// | spectrum_smoother: per-bin attack/decay smoothing of FFT magnitudes |
// | Optional peak hold: define SPECTRUM_PEAK_HOLD_EN                    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module spectrum_smoother
  import spectrum_pkg::*;
#(
  parameter int unsigned NUM_BINS     = 256,
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned ATTACK_SHIFT = 0,
  parameter int unsigned DECAY_SHIFT  = 3,
  parameter int unsigned PEAK_DECAY   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [ADDR_W-1:0] mag_addr,
  input  logic [DATA_W-1:0] mag_data,
  input  logic              mag_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] peak_data,
  output logic              frame_done,
  output logic              busy
);

  localparam int unsigned      DW1      = DATA_W + 1;
  localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(NUM_BINS - 1);

  state_t            state, next_state;
  logic [ADDR_W-1:0] sweep_cnt, next_cnt;

  logic              s0_valid;
  logic [ADDR_W-1:0] s0_addr;
  logic [DATA_W-1:0] s0_data;
  logic              accept, fire, fwd;

  logic              hist_we;
  logic [ADDR_W-1:0] hist_waddr;
  logic [DATA_W-1:0] hist_wdata, hist_rdata;

  logic [DATA_W-1:0] old_val, y, peak_next;
  logic [DW1-1:0]    old_x, new_x, diff, step, y_x;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_SWEEP;
      sweep_cnt <= '0;
    end else begin
      state     <= next_state;
      sweep_cnt <= next_cnt;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = sweep_cnt;
    case (state)
      ST_SWEEP: begin
        if (clear) begin
          next_cnt = '0;
        end else if (sweep_cnt == LAST_BIN) begin
          next_state = ST_RUN;
          next_cnt   = '0;
        end else begin
          next_cnt = sweep_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (clear) begin
          next_state = ST_SWEEP;
          next_cnt   = '0;
        end
      end
      default: begin
        next_state = ST_SWEEP;
        next_cnt   = '0;
      end
    endcase
  end

  assign busy   = (state == ST_SWEEP);
  // A clear in RUN kills both the incoming sample and the one in stage 1.
  assign accept = mag_valid && (state == ST_RUN) && !clear;
  assign fire   = s0_valid  && (state == ST_RUN) && !clear;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_valid <= 1'b0;
      s0_addr  <= '0;
      s0_data  <= '0;
    end else begin
      s0_valid <= accept;
      if (accept) begin
        s0_addr <= mag_addr;
        s0_data <= mag_data;
      end
    end
  end

  assign hist_we    = busy || fire;
  assign hist_waddr = busy ? sweep_cnt : s0_addr;
  assign hist_wdata = busy ? '0 : y;

  bin_ram #(
    .DEPTH (NUM_BINS),
    .AW    (ADDR_W),
    .W     (DATA_W)
  ) u_hist_ram (
    .clk   (clk),
    .we    (hist_we),
    .waddr (hist_waddr),
    .wdata (hist_wdata),
    .raddr (mag_addr),
    .rdata (hist_rdata)
  );

  // The RAM read for a back-to-back repeat of a bin misses the write still in flight.
  assign fwd     = out_valid && (out_addr == s0_addr);
  assign old_val = fwd ? out_data : hist_rdata;

  always_comb begin
    old_x = {1'b0, old_val};
    new_x = {1'b0, s0_data};
    diff  = '0;
    step  = '0;
    y_x   = old_x;
    if (new_x > old_x) begin
      diff = new_x - old_x;
      step = DW1'(min_step(32'(diff), ATTACK_SHIFT));
      y_x  = old_x + step;
    end else if (new_x < old_x) begin
      diff = old_x - new_x;
      step = DW1'(min_step(32'(diff), DECAY_SHIFT));
      y_x  = old_x - step;
    end
  end

  assign y = y_x[DATA_W-1:0];

`ifdef SPECTRUM_PEAK_HOLD_EN
  localparam int unsigned FRAME_W = 16;
  localparam int unsigned PW      = DATA_W + FRAME_W;

  logic [FRAME_W-1:0] frame_cnt, last_tag, old_tag, elapsed;
  logic [PW-1:0]      peak_rdata, peak_wdata;
  logic [DATA_W-1:0]  old_peak, decayed;
  logic [31:0]        dec_amt;

  // Each word carries the frame count at its last write; decay owed is settled on read.
  bin_ram #(
    .DEPTH (NUM_BINS),
    .AW    (ADDR_W),
    .W     (PW)
  ) u_peak_ram (
    .clk   (clk),
    .we    (hist_we),
    .waddr (hist_waddr),
    .wdata (peak_wdata),
    .raddr (mag_addr),
    .rdata (peak_rdata)
  );

  always_comb begin
    old_peak = fwd ? peak_data : peak_rdata[PW-1:FRAME_W];
    old_tag  = fwd ? last_tag  : peak_rdata[FRAME_W-1:0];
    elapsed  = frame_cnt - old_tag;
    dec_amt  = 32'(elapsed) * PEAK_DECAY;
    decayed  = (dec_amt >= 32'(old_peak)) ? '0 : old_peak - DATA_W'(dec_amt);
    peak_next  = (y > decayed) ? y : decayed;
    peak_wdata = busy ? {{DATA_W{1'b0}}, frame_cnt} : {peak_next, frame_cnt};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      last_tag  <= '0;
    end else if (fire) begin
      last_tag <= frame_cnt;
      if (s0_addr == LAST_BIN) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
`else
  assign peak_next = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_addr   <= '0;
      out_data   <= '0;
      peak_data  <= '0;
    end else begin
      out_valid  <= fire;
      frame_done <= fire && (s0_addr == LAST_BIN);
      if (fire) begin
        out_addr  <= s0_addr;
        out_data  <= y;
        peak_data <= peak_next;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spectrum_smoother.sv
// +--------------------------------------------------------------------+
// | tb_spectrum_smoother: directed vectors for spectrum_smoother        |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_spectrum_smoother;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       mag_valid = 1'b0;
  logic [7:0] mag_addr = '0;
  logic [8:0] mag_data = '0;
  logic [7:0] out_addr;
  logic [8:0] out_data;
  logic       out_valid;
  logic [8:0] peak_data;
  logic       frame_done;
  logic       busy;

  int total = 0;
  int bad   = 0;

  spectrum_smoother dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .mag_addr   (mag_addr),
    .mag_data   (mag_data),
    .mag_valid  (mag_valid),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .peak_data  (peak_data),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [8:0] data;
    logic [8:0] exp;
    logic [8:0] pk;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [8:0] pexp(input logic [8:0] v);
`ifdef SPECTRUM_PEAK_HOLD_EN
    return v;
`else
    return (v == v) ? 9'd0 : 9'd0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      n++;
      step();
    end
  endtask

  // Isolated sample; returns with its result visible (T+2).
  task automatic apply_one(input logic [7:0] a, input logic [8:0] d);
    mag_addr  = a;
    mag_data  = d;
    mag_valid = 1'b1;
    step();
    mag_valid = 1'b0;
    check("lat_t1_quiet", out_valid, 0);
    step();
  endtask

  task automatic send_frame(input logic [8:0] v3, output int nvalid, output int nfd,
                            output int nfdbad, output logic [8:0] o3, output logic [8:0] p3);
    nvalid = 0; nfd = 0; nfdbad = 0; o3 = '1; p3 = '1;
    for (int c = 0; c < 258; c++) begin
      if (c < 256) begin
        mag_valid = 1'b1;
        mag_addr  = c[7:0];
        mag_data  = (c == 3) ? v3 : 9'd0;
      end else begin
        mag_valid = 1'b0;
      end
      step();
      if (out_valid === 1'b1) begin
        nvalid++;
        if (out_addr == 8'd3) begin
          o3 = out_data;
          p3 = peak_data;
        end
      end
      if (frame_done === 1'b1) nfd++;
      if (frame_done !== (out_valid && out_addr == 8'd255)) nfdbad++;
    end
  endtask

  initial begin
    int n, emitted, nv, nf, nb;
    logic [8:0] o3, p3;

    vecs[0]  = '{8'd5,  9'd400, 9'd400, 9'd400};
    vecs[1]  = '{8'd5,  9'd0,   9'd350, 9'd400};
    vecs[2]  = '{8'd5,  9'd0,   9'd307, 9'd400};
    vecs[3]  = '{8'd5,  9'd0,   9'd269, 9'd400};
    vecs[4]  = '{8'd5,  9'd0,   9'd236, 9'd400};
    vecs[5]  = '{8'd9,  9'd100, 9'd100, 9'd100};
    vecs[6]  = '{8'd9,  9'd50,  9'd94,  9'd100};
    vecs[7]  = '{8'd9,  9'd200, 9'd200, 9'd200};
    vecs[8]  = '{8'd9,  9'd200, 9'd200, 9'd200};
    vecs[9]  = '{8'd10, 9'd5,   9'd5,   9'd5};
    vecs[10] = '{8'd10, 9'd0,   9'd4,   9'd5};
    vecs[11] = '{8'd11, 9'd511, 9'd511, 9'd511};
    vecs[12] = '{8'd11, 9'd0,   9'd448, 9'd511};
    vecs[13] = '{8'd12, 9'd7,   9'd7,   9'd7};
    vecs[14] = '{8'd12, 9'd7,   9'd7,   9'd7};
    vecs[15] = '{8'd12, 9'd15,  9'd15,  9'd15};

    // Reset state
    repeat (3) step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_peak", peak_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 1);
    rst_n = 1'b1;
    wait_idle(n);
    check("sweep_len", n, 256);

    foreach (vecs[i]) begin
      apply_one(vecs[i].addr, vecs[i].data);
      check("vec_valid", out_valid, 1);
      check("vec_addr", out_addr, vecs[i].addr);
      check("vec_data", out_data, vecs[i].exp);
      check("vec_peak", peak_data, pexp(vecs[i].pk));
      step();
      check("vec_drop", out_valid, 0);
      check("vec_hold", out_data, vecs[i].exp);
    end

    // Back-to-back same bin: forwarding
    mag_addr = 8'd7; mag_data = 9'd100; mag_valid = 1'b1;
    step();
    mag_data = 9'd0;
    step();
    mag_valid = 1'b0;
    check("b2b_first", out_data, 100);
    check("b2b_first_v", out_valid, 1);
    step();
    check("b2b_second", out_data, 88);
    check("b2b_second_v", out_valid, 1);
    step();
    check("b2b_end_v", out_valid, 0);
    apply_one(8'd7, 9'd0);
    check("b2b_hist", out_data, 77);

    mag_addr = 8'd8; mag_data = 9'd200; mag_valid = 1'b1;
    step();
    mag_data = 9'd0;
    step();
    check("tri_a", out_data, 200);
    step();
    mag_valid = 1'b0;
    check("tri_b", out_data, 175);
    step();
    check("tri_c", out_data, 154);

    // Clear mid-stream
    step();
    mag_addr = 8'd20; mag_data = 9'd50; mag_valid = 1'b1;
    step();
    mag_addr = 8'd21;
    step();
    check("clr_pre_data", out_data, 50);
    check("clr_pre_v", out_valid, 1);
    mag_addr = 8'd22; clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_flush", out_valid, 0);
    check("clr_busy", busy, 1);
    mag_addr = 8'd5; mag_data = 9'd300; mag_valid = 1'b1;
    n = 0; emitted = 0;
    while (busy === 1'b1 && n < 2000) begin
      n++;
      if (out_valid === 1'b1) emitted++;
      step();
    end
    mag_valid = 1'b0;
    check("clr_sweep_len", n, 256);
    repeat (3) begin
      if (out_valid === 1'b1) emitted++;
      step();
    end
    check("clr_dropped", emitted, 0);
    apply_one(8'd5, 9'd20);
    check("clr_bin5", out_data, 20);
    apply_one(8'd20, 9'd0);
    check("clr_bin20", out_data, 0);

    // Full frames; bin 3 peaks
    send_frame(9'd300, nv, nf, nb, o3, p3);
    check("f1_valid", nv, 256);
    check("f1_fd_cnt", nf, 1);
    check("f1_fd_bad", nb, 0);
    check("f1_bin3", o3, 300);
    check("f1_peak", p3, pexp(9'd300));
    send_frame(9'd0, nv, nf, nb, o3, p3);
    check("f2_fd_cnt", nf, 1);
    check("f2_bin3", o3, 263);
    check("f2_peak", p3, pexp(9'd299));
    send_frame(9'd0, nv, nf, nb, o3, p3);
    check("f3_fd_bad", nb, 0);
    check("f3_bin3", o3, 231);
    check("f3_peak", p3, pexp(9'd298));

    // Reset mid-stream
    mag_addr = 8'd100; mag_data = 9'd60; mag_valid = 1'b1;
    step();
    mag_addr = 8'd101;
    step();
    check("mid_pre_v", out_valid, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    mag_valid = 1'b0;
    check("mid_rst_v", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_addr", out_addr, 0);
    check("mid_rst_fd", frame_done, 0);
    check("mid_rst_busy", busy, 1);
    wait_idle(n);
    check("mid_sweep_len", n, 256);
    apply_one(8'd5, 9'd0);
    check("mid_bin5_zero", out_data, 0);
    apply_one(8'd5, 9'd400);
    check("mid_bin5_400", out_data, 400);
    check("mid_bin5_addr", out_addr, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
